// File: rtl/fifo_sync_prog_pkg.sv
// fifo_sync_prog_pkg: shared defaults and read-mode type for the programmable FIFO
package fifo_sync_prog_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;
   typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
endpackage

// File: rtl/fifo_sync_prog_mem.sv
// fifo_sync_prog_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
module fifo_sync_prog_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with programmable thresholds, occupancy count and optional FWFT reads
module fifo_sync_prog
   import fifo_sync_prog_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_WIDTH,
   parameter int FIFO_DEPTH = DEF_DEPTH,
   parameter int AF_THRESH = FIFO_DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter bit FWFT = 1'b0,
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam fifo_mode_e MODE = FWFT ? FIFO_FWFT : FIFO_STD;
   if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH >= FIFO_DEPTH) begin : g_bad_thresh
      $error("fifo_sync_prog: thresholds must satisfy 1 <= AE_THRESH < AF_THRESH < FIFO_DEPTH");
   end
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [FIFO_WIDTH-1:0] rd_data, dout_r;
   logic vld_r, wr_ok, rd_ok;
   // explicit wrap so non-power-of-two depths work
   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return p == PTR_W'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   fifo_sync_prog_mem #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PTR_W)) u_mem (
      .clk(clk),
      .we(wr_ok),
      .waddr(wr_ptr),
      .wdata(data_in),
      .raddr(rd_ptr),
      .rdata(rd_data)
   );
   always_comb begin
      full = count == CNT_W'(FIFO_DEPTH);
      empty = count == '0;
      almostfull = count >= CNT_W'(AF_THRESH) && !full;
      almostempty = !empty && count <= CNT_W'(AE_THRESH);
      wr_ok = wr_en && !full && !rst;
      rd_ok = rd_en && !empty && !rst;
      data_out = MODE == FIFO_FWFT ? rd_data : dout_r;
      rd_valid = MODE == FIFO_FWFT ? !empty : vld_r;
   end
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         wr_ack <= 1'b0;
         overflow <= 1'b0;
         underflow <= 1'b0;
         vld_r <= 1'b0;
         dout_r <= '0;
      end else begin
         wr_ptr <= wr_ok ? inc(wr_ptr) : wr_ptr;
         rd_ptr <= rd_ok ? inc(rd_ptr) : rd_ptr;
         count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
         wr_ack <= wr_ok;
         overflow <= wr_en && full;
         underflow <= rd_en && empty;
         vld_r <= rd_ok;
         dout_r <= rd_ok ? rd_data : dout_r;
      end
endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: three FIFO configurations checked against a queue-based reference model
module tb_fifo_sync_prog;
   localparam int DEP [3] = '{8, 8, 6};
   localparam int AFT [3] = '{7, 7, 4};
   localparam int AET [3] = '{1, 1, 2};
   localparam bit FWM [3] = '{1'b0, 1'b1, 1'b0};
   logic clk = 1'b0, rst = 1'b1;
   logic [2:0][15:0] din = '0;
   logic [2:0][15:0] dout;
   logic [2:0] wr = '0, rd = '0;
   logic [2:0] vld, ack, ovf, unf, ful, emp, af, ae;
   logic [3:0] c0, c1;
   logic [2:0] c2;
   logic [2:0][3:0] cnt;
   logic [15:0] q [3][$];
   logic [2:0] e_ack, e_ovf, e_unf, e_vld;
   logic [2:0][15:0] e_dout;
   int checks = 0, errors = 0;
   assign cnt = {{1'b0, c2}, c1, c0};
   always #5 clk = ~clk;
   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .data_in(din[0]), .wr_en(wr[0]), .rd_en(rd[0]), .data_out(dout[0]),
      .rd_valid(vld[0]), .wr_ack(ack[0]), .overflow(ovf[0]), .underflow(unf[0]), .full(ful[0]),
      .empty(emp[0]), .almostfull(af[0]), .almostempty(ae[0]), .count(c0));
   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .data_in(din[1]), .wr_en(wr[1]), .rd_en(rd[1]), .data_out(dout[1]),
      .rd_valid(vld[1]), .wr_ack(ack[1]), .overflow(ovf[1]), .underflow(unf[1]), .full(ful[1]),
      .empty(emp[1]), .almostfull(af[1]), .almostempty(ae[1]), .count(c1));
   fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_THRESH(4), .AE_THRESH(2), .FWFT(1'b0)) dut2 (
      .clk(clk), .rst(rst), .data_in(din[2]), .wr_en(wr[2]), .rd_en(rd[2]), .data_out(dout[2]),
      .rd_valid(vld[2]), .wr_ack(ack[2]), .overflow(ovf[2]), .underflow(unf[2]), .full(ful[2]),
      .empty(emp[2]), .almostfull(af[2]), .almostempty(ae[2]), .count(c2));
   // advances the reference model by one clock using the inputs currently driven, then waits past the edge
   task automatic step();
      for (int i = 0; i < 3; i++) begin
         int n = q[i].size();
         bit wa = wr[i] && n < DEP[i];
         bit ra = rd[i] && n > 0;
         if (rst) begin
            q[i].delete();
            {e_ack[i], e_ovf[i], e_unf[i], e_vld[i]} = '0;
            e_dout[i] = '0;
         end else begin
            e_ack[i] = wa;
            e_ovf[i] = wr[i] && n == DEP[i];
            e_unf[i] = rd[i] && n == 0;
            e_vld[i] = ra;
            if (ra) e_dout[i] = q[i].pop_front();
            if (wa) q[i].push_back(din[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1; wr = '1; rd = '1;
      step();
      rst = 1'b0; wr = '0; rd = '0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cnt[i] !== 4'd0 || emp[i] !== 1'b1 || {ful[i], af[i], ae[i]} !== 3'b000) begin
            errors++; $display("FAIL reset_flags[%0d] count=%0d empty=%b full=%b af=%b ae=%b required count=0 empty=1 others 0", i, cnt[i], emp[i], ful[i], af[i], ae[i]);
         end
         checks++;
         if ({ack[i], ovf[i], unf[i], vld[i]} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses[%0d] ack/ovf/unf/vld=%b%b%b%b required 0000", i, ack[i], ovf[i], unf[i], vld[i]);
         end
      end
      checks++;
      if (dout[0] !== 16'h0) begin errors++; $display("FAIL reset_dout got %h required 0000", dout[0]); end
      rd = '1;
      step();
      rd = '0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (unf[i] !== 1'b1 || cnt[i] !== 4'd0) begin
            errors++; $display("FAIL idle_underflow[%0d] unf=%b count=%0d required 1 and 0", i, unf[i], cnt[i]);
         end
      end
      step();
      checks++;
      if (unf !== 3'b000) begin errors++; $display("FAIL underflow_pulse got %b required 000", unf); end
   endtask
   task automatic test_fill();
      for (int k = 1; k <= 9; k++) begin
         din[0] = 16'(k); wr[0] = 1'b1;
         step();
         checks++;
         if (ack[0] !== (k <= 8) || ovf[0] !== (k == 9) || cnt[0] !== 4'(k > 8 ? 8 : k)) begin
            errors++; $display("FAIL fill_k%0d ack=%b ovf=%b count=%0d required %b %b %0d", k, ack[0], ovf[0], cnt[0], k <= 8, k == 9, k > 8 ? 8 : k);
         end
         checks++;
         if (af[0] !== (k == 7) || ful[0] !== (k >= 8)) begin
            errors++; $display("FAIL fill_flags_k%0d af=%b full=%b required %b %b", k, af[0], ful[0], k == 7, k >= 8);
         end
      end
      wr[0] = 1'b0;
   endtask
   task automatic test_drain_std();
      for (int k = 1; k <= 8; k++) begin
         rd[0] = 1'b1;
         step();
         checks++;
         if (dout[0] !== 16'(k) || vld[0] !== 1'b1 || cnt[0] !== 4'(8 - k)) begin
            errors++; $display("FAIL drain_k%0d dout=%h vld=%b count=%0d required %h 1 %0d", k, dout[0], vld[0], cnt[0], 16'(k), 8 - k);
         end
         checks++;
         if (ae[0] !== (k == 7) || emp[0] !== (k == 8)) begin
            errors++; $display("FAIL drain_flags_k%0d ae=%b empty=%b required %b %b", k, ae[0], emp[0], k == 7, k == 8);
         end
      end
      rd[0] = 1'b0;
      step();
      checks++;
      if (vld[0] !== 1'b0 || dout[0] !== 16'h0008) begin
         errors++; $display("FAIL drain_hold vld=%b dout=%h required 0 0008", vld[0], dout[0]);
      end
   endtask
   task automatic test_fwft();
      din[1] = 16'hABCD; wr[1] = 1'b1;
      step();
      wr[1] = 1'b0;
      checks++;
      if (dout[1] !== 16'hABCD || vld[1] !== 1'b1) begin
         errors++; $display("FAIL fwft_visible dout=%h vld=%b required abcd 1", dout[1], vld[1]);
      end
      rd[1] = 1'b1;
      step();
      rd[1] = 1'b0;
      checks++;
      if (emp[1] !== 1'b1 || vld[1] !== 1'b0) begin
         errors++; $display("FAIL fwft_pop empty=%b vld=%b required 1 0", emp[1], vld[1]);
      end
   endtask
   task automatic test_simultaneous();
      logic [15:0] oldest;
      for (int k = 0; k < 8; k++) begin
         din[0] = 16'($urandom); wr[0] = 1'b1;
         step();
      end
      oldest = q[0][0];
      din[0] = 16'h5555; rd[0] = 1'b1;
      step();
      checks++;
      if (dout[0] !== oldest || ovf[0] !== 1'b1 || ack[0] !== 1'b0 || cnt[0] !== 4'd7) begin
         errors++; $display("FAIL full_wr_rd dout=%h ovf=%b ack=%b count=%0d required %h 1 0 7", dout[0], ovf[0], ack[0], cnt[0], oldest);
      end
      wr[0] = 1'b0;
      for (int k = 0; k < 7; k++) step();
      din[0] = 16'h7777; wr[0] = 1'b1;
      step();
      checks++;
      if (unf[0] !== 1'b1 || ack[0] !== 1'b1 || cnt[0] !== 4'd1) begin
         errors++; $display("FAIL empty_wr_rd unf=%b ack=%b count=%0d required 1 1 1", unf[0], ack[0], cnt[0]);
      end
      wr[0] = 1'b0;
      step();
      rd[0] = 1'b0;
      checks++;
      if (dout[0] !== 16'h7777 || emp[0] !== 1'b1) begin
         errors++; $display("FAIL empty_wr_rd_data dout=%h empty=%b required 7777 1", dout[0], emp[0]);
      end
   endtask
   task automatic test_reset_mid();
      for (int k = 0; k < 5; k++) begin
         din[0] = 16'($urandom); wr[0] = 1'b1;
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0; wr[0] = 1'b0;
      checks++;
      if (cnt[0] !== 4'd0 || emp[0] !== 1'b1 || ack[0] !== 1'b0) begin
         errors++; $display("FAIL mid_reset count=%0d empty=%b ack=%b required 0 1 0", cnt[0], emp[0], ack[0]);
      end
      din[0] = 16'h1234; wr[0] = 1'b1;
      step();
      wr[0] = 1'b0; rd[0] = 1'b1;
      step();
      rd[0] = 1'b0;
      checks++;
      if (dout[0] !== 16'h1234 || vld[0] !== 1'b1) begin
         errors++; $display("FAIL post_reset_roundtrip dout=%h vld=%b required 1234 1", dout[0], vld[0]);
      end
   endtask
   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         int wb = (c / 100) % 2 ? 30 : 70;
         for (int i = 0; i < 3; i++) begin
            din[i] = 16'($urandom);
            wr[i] = $urandom_range(0, 99) < wb;
            rd[i] = $urandom_range(0, 99) < 100 - wb;
         end
         step();
         for (int i = 0; i < 3; i++) begin
            int n = q[i].size();
            checks++;
            if (cnt[i] !== 4'(n)) begin errors++; $display("FAIL rand_count[%0d] cyc %0d got %0d required %0d", i, c, cnt[i], n); end
            checks++;
            if ({ful[i], emp[i], af[i], ae[i]} !== {n == DEP[i], n == 0, n >= AFT[i] && n < DEP[i], n > 0 && n <= AET[i]}) begin
               errors++; $display("FAIL rand_flags[%0d] cyc %0d full/empty/af/ae=%b%b%b%b count_model=%0d", i, c, ful[i], emp[i], af[i], ae[i], n);
            end
            checks++;
            if ({ack[i], ovf[i], unf[i]} !== {e_ack[i], e_ovf[i], e_unf[i]}) begin
               errors++; $display("FAIL rand_pulses[%0d] cyc %0d got %b%b%b required %b%b%b", i, c, ack[i], ovf[i], unf[i], e_ack[i], e_ovf[i], e_unf[i]);
            end
            checks++;
            if (FWM[i]) begin
               if (vld[i] !== (n > 0) || (n > 0 && dout[i] !== q[i][0])) begin
                  errors++; $display("FAIL rand_fwft[%0d] cyc %0d vld=%b dout=%h required %b %h", i, c, vld[i], dout[i], n > 0, n > 0 ? q[i][0] : 16'h0);
               end
            end else if ({vld[i], dout[i]} !== {e_vld[i], e_dout[i]}) begin
               errors++; $display("FAIL rand_read[%0d] cyc %0d vld=%b dout=%h required %b %h", i, c, vld[i], dout[i], e_vld[i], e_dout[i]);
            end
         end
      end
      wr = '0; rd = '0;
   endtask
   initial begin
      test_reset();
      test_fill();
      test_drain_std();
      test_fwft();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
